surf4_pps_conditioner: RTL and testbench

Conditions the raw PPS and external-trigger inputs into clean single-cycle pulses in the control WISHBONE clock domain. It sits directly upstream of the ID/control block's `pps_o` and `ext_trig_o` outputs, which fan out `global_pps` to the HK collector, RFP and LAB4 blocks.
- Synchronizes and edge-detects both inputs.
- Qualifies the external PPS by its period before trusting it.
- Substitutes an internally timed PPS whenever the external one is absent or unqualified.

---
 rtl/surf4_pps_conditioner.sv | 175 +++++++++++++++++
 tb/tb_surf4_pps_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/surf4_pps_conditioner.sv
// surf4_pps_conditioner
//   Turns the raw PPS and external-trigger inputs into clean one-cycle pulses
//   in the control (wbc_clk) domain. The external PPS is trusted only after
//   LOCK_EDGES consecutive intervals fall inside PPS_PERIOD +/- PPS_TOL.
//   When the external PPS is absent or unqualified, an internally timed PPS
//   can take its place.
//
//   Optional feature macro: SURF4_FAKE_PPS_EN
//     defined   : internally timed pulses in FREE, plus one pulse on lock loss
//     undefined : pps_o pulses only on the locking edge and on accepted
//                 edges in LOCKED
//
// Ports
//   clk_i            : control bus clock
//   rst_i            : asynchronous active-high reset
//   pps_i            : raw PPS (asynchronous)
//   ext_trig_i       : raw external trigger (asynchronous)
//   pps_o            : one-cycle PPS pulse
//   ext_trig_o       : one-cycle trigger pulse
//   pps_locked_o     : high while pps_o follows the external PPS
//   pps_loss_count_o : saturating count of lock losses
module surf4_pps_conditioner #(
  parameter int unsigned PPS_PERIOD   = 33333333,
  parameter int unsigned PPS_TOL      = 3333,
  parameter int unsigned LOCK_EDGES   = 2,
  parameter int unsigned TRIG_HOLDOFF = 1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pps_i,
  input  logic       ext_trig_i,
  output logic       pps_o,
  output logic       ext_trig_o,
  output logic       pps_locked_o,
  output logic [7:0] pps_loss_count_o
);

  localparam logic [31:0] WIN_LO = 32'(PPS_PERIOD - PPS_TOL);
  localparam logic [31:0] WIN_HI = 32'(PPS_PERIOD + PPS_TOL);
  localparam logic [31:0] TMO    = WIN_HI + 32'd1;

  localparam int unsigned GW = (LOCK_EDGES > 0) ? $clog2(LOCK_EDGES + 1) : 1;
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_EDGES - 1);

  localparam int unsigned HW = (TRIG_HOLDOFF > 0) ? $clog2(TRIG_HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD = HW'(TRIG_HOLDOFF);

`ifdef SURF4_FAKE_PPS_EN
  localparam int unsigned PW = (PPS_PERIOD > 1) ? $clog2(PPS_PERIOD) : 1;
  localparam logic [PW-1:0] PH_TERM = PW'(PPS_PERIOD - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
`endif

  typedef enum logic {FREE, LOCKED} state_t;

  state_t         state;
  logic [2:0]     pps_sync;
  logic [2:0]     trig_sync;
  logic           pps_edge;
  logic           trig_edge;
  logic [31:0]    since;
  logic [GW-1:0]  good_cnt;
  logic [HW-1:0]  holdoff;
  logic           interval_good;
`ifdef SURF4_FAKE_PPS_EN
  logic [PW-1:0]  phase;
`endif

  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  // used by the registered rising-edge detector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pps_sync  <= '0;
      trig_sync <= '0;
      pps_edge  <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      pps_sync  <= {pps_sync[1:0], pps_i};
      trig_sync <= {trig_sync[1:0], ext_trig_i};
      pps_edge  <= pps_sync[1] & ~pps_sync[2];
      trig_edge <= trig_sync[1] & ~trig_sync[2];
    end
  end

  assign interval_good = (since >= WIN_LO) && (since <= WIN_HI);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= FREE;
      since            <= '1;
      good_cnt         <= '0;
      pps_o            <= 1'b0;
      pps_locked_o     <= 1'b0;
      pps_loss_count_o <= '0;
`ifdef SURF4_FAKE_PPS_EN
      phase            <= '0;
`endif
    end else begin
      pps_o <= 1'b0;
      if (since != '1) since <= since + 32'd1;

      case (state)
        FREE: begin
`ifdef SURF4_FAKE_PPS_EN
          if (phase == PH_TERM) begin
            phase <= '0;
            pps_o <= 1'b1;
          end else begin
            phase <= phase + PH_ONE;
          end
`endif
          if (pps_edge) begin
            since <= 32'd1;
            if (interval_good) begin
              // This edge is the LOCK_EDGES-th good interval in a row.
              // A coincident terminal phase merges into this single pulse.
              if (good_cnt == LOCK_LAST) begin
                state        <= LOCKED;
                pps_o        <= 1'b1;
                pps_locked_o <= 1'b1;
                good_cnt     <= '0;
`ifdef SURF4_FAKE_PPS_EN
                phase        <= '0;
`endif
              end else begin
                good_cnt <= good_cnt + GW'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end
        end

        LOCKED: begin
`ifdef SURF4_FAKE_PPS_EN
          phase <= '0;
`endif
          // Early edges are glitches: since keeps running so the real
          // edge that follows is still measured from the last good one.
          if (pps_edge && (since >= WIN_LO)) begin
            pps_o <= 1'b1;
            since <= 32'd1;
          end else if (since == TMO) begin
            state        <= FREE;
            pps_locked_o <= 1'b0;
            good_cnt     <= '0;
            if (pps_loss_count_o != 8'hFF)
              pps_loss_count_o <= pps_loss_count_o + 8'd1;
`ifdef SURF4_FAKE_PPS_EN
            pps_o        <= 1'b1;
`endif
          end
        end

        default: state <= FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      holdoff    <= '0;
      ext_trig_o <= 1'b0;
    end else begin
      ext_trig_o <= 1'b0;
      if (holdoff != '0) begin
        holdoff <= holdoff - HW'(1);
      end else if (trig_edge) begin
        ext_trig_o <= 1'b1;
        holdoff    <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_surf4_pps_conditioner.sv
module tb_surf4_pps_conditioner;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pps_i = 1'b0;
  logic       ext_trig_i = 1'b0;
  logic       pps_o;
  logic       ext_trig_o;
  logic       pps_locked_o;
  logic [7:0] pps_loss_count_o;

`ifdef SURF4_FAKE_PPS_EN
  localparam bit FAKE = 1'b1;
`else
  localparam bit FAKE = 1'b0;
`endif

  surf4_pps_conditioner #(
    .PPS_PERIOD  (100),
    .PPS_TOL     (4),
    .LOCK_EDGES  (2),
    .TRIG_HOLDOFF(10)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pps_i           (pps_i),
    .ext_trig_i      (ext_trig_i),
    .pps_o           (pps_o),
    .ext_trig_o      (ext_trig_o),
    .pps_locked_o    (pps_locked_o),
    .pps_loss_count_o(pps_loss_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit trig;
    bit exp_trig;
  } tvec_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int sched[$];
  int pulses[$];
  int expq[$];
  bit prev_pps = 1'b0;
  bit locked_seen = 1'b0;
  tvec_t tv[20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edge number cyc+1 samples pps_i; raw pulses are 2 cycles wide.
  task automatic tick(input bit trig);
    int nxt;
    bit p;
    nxt = cyc + 1;
    p = 1'b0;
    foreach (sched[i]) if (nxt == sched[i] || nxt == sched[i] + 1) p = 1'b1;
    pps_i = p;
    ext_trig_i = trig;
    @(posedge clk_i);
    #1;
    cyc = nxt;
    if (pps_o) begin
      pulses.push_back(cyc);
      chk("pps_not_back_to_back", int'(prev_pps), 0);
    end
    if (pps_locked_o) locked_seen = 1'b1;
    prev_pps = pps_o;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick(1'b0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    pps_i = 1'b0;
    ext_trig_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_pps_o", int'(pps_o), 0);
    chk("rst_trig_o", int'(ext_trig_o), 0);
    chk("rst_locked", int'(pps_locked_o), 0);
    chk("rst_loss", int'(pps_loss_count_o), 0);
    rst_i = 1'b0;
    cyc = 0;
    sched.delete();
    pulses.delete();
    prev_pps = 1'b0;
    locked_seen = 1'b0;
  endtask

  task automatic cmp_pulses(input string name);
    chk({name, "_count"}, pulses.size(), expq.size());
    foreach (expq[i]) begin
      if (i < pulses.size()) chk({name, "_at"}, pulses[i], expq[i]);
      else chk({name, "_missing"}, -1, expq[i]);
    end
  endtask

  initial begin
    // Trigger table: index k is the cycle at which the raw input is sampled.
    foreach (tv[k]) tv[k] = '{trig: 1'b0, exp_trig: 1'b0};
    tv[0].trig = 1'b1;  tv[1].trig = 1'b1;
    tv[5].trig = 1'b1;  tv[6].trig = 1'b1;
    tv[12].trig = 1'b1; tv[13].trig = 1'b1;
    tv[3].exp_trig = 1'b1;
    tv[15].exp_trig = 1'b1;

    do_reset();
    foreach (tv[k]) begin
      tick(tv[k].trig);
      chk($sformatf("trig_vec%0d", k), int'(ext_trig_o), int'(tv[k].exp_trig));
    end

    // Free-running internal PPS with no external input.
    do_reset();
    run_to(350);
    expq.delete();
    if (FAKE) expq = '{100, 200, 300};
    cmp_pulses("free_run");
    chk("free_run_unlocked", int'(locked_seen), 0);

    // Lock, glitch, loss, relock.
    do_reset();
    sched = '{10, 112, 214, 316, 418, 448, 520};
    run_to(216);
    chk("prelock_locked", int'(pps_locked_o), 0);
    run_to(217);
    chk("lock_locked", int'(pps_locked_o), 1);
    chk("lock_pulse", int'(pps_o), 1);
    run_to(319);
    chk("locked_follow", int'(pps_o), 1);
    run_to(451);
    chk("glitch_no_pulse", int'(pps_o), 0);
    chk("glitch_still_locked", int'(pps_locked_o), 1);
    run_to(523);
    chk("post_glitch_pulse", int'(pps_o), 1);
    run_to(627);
    chk("pre_timeout_locked", int'(pps_locked_o), 1);
    chk("pre_timeout_loss", int'(pps_loss_count_o), 0);
    run_to(628);
    chk("timeout_locked", int'(pps_locked_o), 0);
    chk("timeout_loss", int'(pps_loss_count_o), 1);
    chk("timeout_pulse", int'(pps_o), FAKE ? 1 : 0);
    run_to(850);
    sched.push_back(860);
    sched.push_back(962);
    sched.push_back(1064);
    run_to(1066);
    chk("relock_pre", int'(pps_locked_o), 0);
    run_to(1067);
    chk("relock_locked", int'(pps_locked_o), 1);
    chk("relock_loss", int'(pps_loss_count_o), 1);
    chk("relock_pulse", int'(pps_o), 1);
    expq.delete();
    if (FAKE) expq = '{100, 200, 217, 319, 421, 523, 628, 728, 828, 928, 1028, 1067};
    else      expq = '{217, 319, 421, 523, 1067};
    cmp_pulses("lock_seq");

    // Asynchronous reset while locked and while pps_o is high.
    rst_i = 1'b1;
    #1;
    chk("midrst_pps_o", int'(pps_o), 0);
    chk("midrst_locked", int'(pps_locked_o), 0);
    chk("midrst_loss", int'(pps_loss_count_o), 0);
    chk("midrst_trig", int'(ext_trig_o), 0);
    do_reset();
    run_to(150);
    expq.delete();
    if (FAKE) expq = '{100};
    cmp_pulses("after_reset");
    chk("after_reset_unlocked", int'(locked_seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
